ifetch_queue: RTL and testbench

//  Fetch stage between the PC/imem pair and the decoder. Issues sequential

---
 rtl/ifq_pkg.sv | 22 ++
 rtl/ifq_fifo.sv | 63 ++++++
 rtl/ifetch_queue.sv | 142 ++++++++++++++
 tb/tb_ifetch_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: queue entry layout, fetch FSM states, fault causes.
package ifq_pkg;

    localparam int IFQ_XLEN = 64;
    localparam int IFQ_ILEN = 32;

    localparam logic [3:0] EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0] EXC_INSTR_ACCESS_FAULT = 4'd1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_ILEN-1:0] instr;
        logic                exc_en;
        logic [3:0]          exc_code;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry circular buffer with wrap-bit pointers; flush empties it in one cycle.
// Head is a registered read (no fall-through); push at full is only legal alongside a pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ifq_entry_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  T            push_dat_i,
    input  logic        pop_i,
    output T            head_o,
    output logic [AW:0] count_o,
    output logic        empty_o
);

    T           mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full;
    logic        pop_eff;
    logic        wr_en;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full    = (count_o == (AW+1)'(DEPTH));
    assign pop_eff = pop_i && !empty_o;
    assign wr_en   = push_i && (!full || pop_eff);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            // The fetch credit scheme must make this unreachable.
            assert (flush_i || !(push_i && full && !pop_eff));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Sequential fetch from a 1-cycle imem into a DEPTH-entry queue; redirect flushes and restarts.
// Latency request->out_valid 2 cycles (1 with IFQ_BYPASS_EN); stops issuing when queue+in-flight reach DEPTH.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int              XLEN     = IFQ_XLEN,
    parameter int              ILEN     = IFQ_ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            imem_exc_en,
    input  logic [3:0]      imem_exc_code,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            out_exc_en,
    output logic [3:0]      out_exc_code,
    output logic [XLEN-1:0] out_exc_val
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    logic            epoch_q;
    logic            req_epoch_q;

    logic [CW-1:0]   count;
    logic            fifo_empty;
    ifq_entry_t      head;
    ifq_entry_t      rsp_entry;
    logic [CW:0]     credits_used;
    logic            issue;
    logic            rsp_acc;
    logic            bypass;
    logic            push;
    logic            pop;

    // Entries already queued plus the one outstanding request bound further issue.
    assign credits_used = {1'b0, count} + (CW+1)'(inflight_q);
    assign issue        = !rst && (state_q == RUN) && !redirect
                          && (credits_used < (CW+1)'(DEPTH));
    assign rsp_acc      = imem_rsp && inflight_q && (req_epoch_q == epoch_q);
    assign rsp_entry    = '{pc: req_pc_q, instr: imem_instr,
                            exc_en: imem_exc_en, exc_code: imem_exc_code};

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_acc && fifo_empty && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push      = rsp_acc && !bypass;
    assign pop       = out_ready && !fifo_empty;
    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .T     (ifq_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect),
        .push_i     (push),
        .push_dat_i (rsp_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        out_valid    = 1'b0;
        out_pc       = '0;
        out_instr    = '0;
        out_exc_en   = 1'b0;
        out_exc_code = '0;
        if (!rst) begin
            if (bypass) begin
                out_valid    = 1'b1;
                out_pc       = rsp_entry.pc;
                out_instr    = rsp_entry.instr;
                out_exc_en   = rsp_entry.exc_en;
                out_exc_code = rsp_entry.exc_code;
            end else if (!fifo_empty) begin
                out_valid    = 1'b1;
                out_pc       = head.pc;
                out_instr    = head.instr;
                out_exc_en   = head.exc_en;
                out_exc_code = head.exc_code;
            end
        end
    end

    assign out_exc_val = out_pc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            state_d    = RUN;
            fetch_pc_d = redirect_pc;
        end else begin
            if (issue)                   fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_acc && imem_exc_en)  state_d    = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            // Responses tagged with an older epoch are from a flushed stream.
            if (redirect) epoch_q <= ~epoch_q;
            if (issue) begin
                req_pc_q    <= fetch_pc_q;
                req_epoch_q <= epoch_q;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus a random stall/redirect run against a queue model.
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP         = 1'b1;
    localparam int FIRST_VALID = 1;
`else
    localparam bit BYP         = 1'b0;
    localparam int FIRST_VALID = 2;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  code;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, redirect, imem_rsp, imem_exc_en, out_ready;
    logic [63:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [3:0]  imem_exc_code;
    logic        imem_req, out_valid, out_exc_en;
    logic [63:0] imem_addr, out_pc, out_exc_val;
    logic [31:0] out_instr;
    logic [3:0]  out_exc_code;

    always #5 clk = ~clk;

    ifetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rsp(imem_rsp),
        .imem_instr(imem_instr), .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_exc_en(out_exc_en), .out_exc_code(out_exc_code), .out_exc_val(out_exc_val)
    );

    int total = 0;
    int bad   = 0;

    // imem environment
    logic        pend_vld = 1'b0;
    logic [63:0] pend_addr = '0;
    logic [63:0] exc_addr = '1;
    bit          rand_exc = 1'b0;

    // reference model
    ent_t        mq[$];
    logic [63:0] m_pc = RESET_PC;
    bit          m_halt = 1'b0;
    bit          m_inf = 1'b0;
    logic [63:0] m_inf_pc = '0;
    bit          exp_req, exp_valid;
    logic [63:0] exp_addr;
    ent_t        exp_head;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0001;
    endfunction

    // One clock: drive at negedge, sample #1 later, then advance the model.
    task automatic tick(input bit r, input bit rdy, input bit redir, input logic [63:0] rpc);
        bit   acc, byp;
        ent_t rsp_e;
        @(negedge clk);
        rst           = r;
        out_ready     = rdy;
        redirect      = redir;
        redirect_pc   = rpc;
        imem_rsp      = pend_vld;
        imem_instr    = instr_of(pend_addr);
        imem_exc_en   = pend_vld && ((pend_addr == exc_addr) || (rand_exc && $urandom_range(0, 63) == 0));
        imem_exc_code = imem_exc_en ? EXC_INSTR_ACCESS_FAULT : 4'd0;
        #1;
        acc   = imem_rsp && m_inf;
        rsp_e = '{pc: m_inf_pc, instr: imem_instr, exc: imem_exc_en, code: imem_exc_code};
        byp   = BYP && (mq.size() == 0) && acc && rdy && !r;
        if (r) begin
            exp_req = 1'b0; exp_valid = 1'b0; exp_addr = '0; exp_head = '0;
        end else begin
            exp_req   = !m_halt && !redir && ((mq.size() + int'(m_inf)) < DEPTH);
            exp_addr  = m_pc;
            exp_valid = byp || (mq.size() != 0);
            exp_head  = byp ? rsp_e : ((mq.size() != 0) ? mq[0] : '0);
        end
        pend_vld  = imem_req;
        pend_addr = imem_addr;
        if (r) begin
            mq.delete(); m_pc = RESET_PC; m_halt = 1'b0; m_inf = 1'b0;
        end else if (redir) begin
            mq.delete(); m_pc = rpc; m_halt = 1'b0; m_inf = 1'b0;
        end else begin
            if (exp_valid && rdy && !byp) void'(mq.pop_front());
            if (acc && !byp)              mq.push_back(rsp_e);
            if (acc && imem_exc_en)       m_halt = 1'b1;
            m_inf    = exp_req;
            m_inf_pc = m_pc;
            if (exp_req) m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
            total++; if (out_pc !== 64'h0 || out_instr !== 32'h0) begin bad++; $display("FAIL reset_data pc=%h instr=%h want=0", out_pc, out_instr); end
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 0, 0);
            total++; if (imem_req !== 1'b1 || imem_addr !== 64'(4 * i)) begin bad++; $display("FAIL stream_issue cyc=%0d got=%b/%h want=1/%h", i, imem_req, imem_addr, 64'(4 * i)); end
            if (i < FIRST_VALID) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid cyc=%0d got=%b want=0", i, out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * (i - FIRST_VALID))) begin bad++; $display("FAIL stream_out cyc=%0d got=%b/%h want=1/%h", i, out_valid, out_pc, 64'(4 * (i - FIRST_VALID))); end
                total++; if (out_instr !== instr_of(64'(4 * (i - FIRST_VALID)))) begin bad++; $display("FAIL stream_instr cyc=%0d got=%h", i, out_instr); end
            end
        end
    endtask

    task automatic test_stall();
        int nreq = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 0);
            if (imem_req === 1'b1) nreq++;
            total++; if (imem_req !== exp_req) begin bad++; $display("FAIL stall_req cyc=%0d got=%b want=%b", i, imem_req, exp_req); end
        end
        total++; if (nreq != DEPTH) begin bad++; $display("FAIL stall_nreq got=%0d want=%0d", nreq, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, 1, 0, 0);
            total++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * i)) begin bad++; $display("FAIL stall_drain k=%0d got=%b/%h want=1/%h", i, out_valid, out_pc, 64'(4 * i)); end
        end
    endtask

    task automatic test_redirect();
        logic [63:0] seen[$];
        tick(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
        tick(0, 1, 1, 64'h100);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_same got=%b want=0", imem_req); end
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0, 0);
            if (i == 0) begin
                total++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin bad++; $display("FAIL redir_first_req got=%b/%h want=1/100", imem_req, imem_addr); end
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed got=%b want=0", out_valid); end
            end
            if (out_valid === 1'b1) seen.push_back(out_pc);
        end
        total++; if (seen.size() < 2 || seen[0] !== 64'h100 || seen[1] !== 64'h104) begin bad++; $display("FAIL redir_order n=%0d first=%h second=%h want=100/104", seen.size(), (seen.size() > 0) ? seen[0] : 64'hx, (seen.size() > 1) ? seen[1] : 64'hx); end
    endtask

    task automatic test_exc();
        int nreq = 0, n8 = 0;
        tick(1, 1, 0, 0);
        exc_addr = 64'h8;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 0);
            if (imem_req === 1'b1) nreq++;
            if (out_valid === 1'b1 && out_pc === 64'h8) begin
                n8++;
                total++; if (out_exc_en !== 1'b1 || out_exc_val !== 64'h8 || out_exc_code !== 4'd1) begin bad++; $display("FAIL exc_tag got=%b/%h/%h want=1/8/1", out_exc_en, out_exc_val, out_exc_code); end
            end else if (out_valid === 1'b1) begin
                total++; if (out_exc_en !== 1'b0) begin bad++; $display("FAIL exc_clean pc=%h got=%b want=0", out_pc, out_exc_en); end
            end
        end
        total++; if (nreq != 4 || n8 != 1) begin bad++; $display("FAIL exc_halt nreq=%0d n8=%0d want=4/1", nreq, n8); end
        exc_addr = '1;
        tick(0, 1, 1, 64'h200);
        tick(0, 1, 0, 0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin bad++; $display("FAIL exc_resume got=%b/%h want=1/200", imem_req, imem_addr); end
    endtask

    task automatic test_flush_full();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0);
        total++; if (out_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL full_state got=%b/%b want=1/0", out_valid, imem_req); end
        tick(0, 0, 1, 64'h300);
        tick(0, 0, 0, 0);
        total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h300) begin bad++; $display("FAIL full_redir got=%b/%b/%h want=0/1/300", out_valid, imem_req, imem_addr); end
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        total++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL full_rst_cycle got=%b/%b want=0/0", out_valid, imem_req); end
        tick(0, 0, 0, 0);
        total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin bad++; $display("FAIL full_rst_after got=%b/%b/%h want=0/1/%h", out_valid, imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_random();
        bit          have_last = 1'b0;
        logic [63:0] last_pc = '0;
        bit          rdy, redir;
        logic [63:0] rpc;
        tick(1, 1, 0, 0);
        rand_exc = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rdy   = ($urandom_range(0, 99) < 60);
            redir = ($urandom_range(0, 99) < 2);
            rpc   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4 : {32'h0, $urandom} & 64'hFFFF_FFFC;
            tick(0, rdy, redir, rpc);
            total++; if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin bad++; $display("FAIL rand_req cyc=%0d got=%b/%h want=%b/%h", i, imem_req, imem_addr, exp_req, exp_addr); end
            total++; if (out_valid !== exp_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", i, out_valid, exp_valid); end
            if (exp_valid) begin
                total++; if (out_pc !== exp_head.pc || out_instr !== exp_head.instr || out_exc_en !== exp_head.exc || out_exc_code !== exp_head.code) begin bad++; $display("FAIL rand_head cyc=%0d got=%h/%h/%b want=%h/%h/%b", i, out_pc, out_instr, out_exc_en, exp_head.pc, exp_head.instr, exp_head.exc); end
            end
            if (redir) have_last = 1'b0;
            else if (out_valid === 1'b1 && rdy) begin
                if (have_last) begin
                    total++; if (out_pc !== last_pc + 64'd4) begin bad++; $display("FAIL rand_seq cyc=%0d got=%h want=%h", i, out_pc, last_pc + 64'd4); end
                end
                have_last = 1'b1;
                last_pc   = out_pc;
            end
        end
        rand_exc = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_rsp = 1'b0; imem_instr = '0; imem_exc_en = 1'b0; imem_exc_code = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_exc();
        test_flush_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
